// File: rtl/lr35902_dbg_tx_arb.sv
// rtl/lr35902_dbg_tx_arb.sv - packet round-robin arbiter sharing the debug UART TX byte stream
// Optional DBG_TX_TAG_EN: prefixes each granted segment with tag byte 8'hE0|owner.
module lr35902_dbg_tx_arb #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_TAG} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_win;
  logic [7:0]      count;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            found;
  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            release_now;

  // Search starts just after the previous winner so every valid requester is served in turn.
  always_comb begin
    win   = last_win;
    cand  = last_win;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_win) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign own_valid   = req_valid[owner];
  assign own_last    = req_last[owner];
  assign own_data    = req_data[{owner, 3'b000} +: 8];
  assign release_now = own_last || (count == 8'(HOLD_MAX - 1));
  assign busy        = (state != S_IDLE);

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (state)
      S_XFER: begin
        tx_valid  = own_valid;
        tx_data   = own_data;
        req_ready = grant & {NUM_REQ{tx_ready & own_valid}};
      end
`ifdef DBG_TX_TAG_EN
      S_TAG: begin
        tx_valid = 1'b1;
        tx_data  = 8'hE0 | 8'(owner);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      grant    <= '0;
      owner    <= '0;
      last_win <= IW'(NUM_REQ - 1);
      count    <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            owner <= win;
            grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
`ifdef DBG_TX_TAG_EN
            state <= S_TAG;
`else
            state <= S_XFER;
`endif
          end
        end
`ifdef DBG_TX_TAG_EN
        S_TAG: begin
          if (tx_ready) state <= S_XFER;
        end
`endif
        S_XFER: begin
          // A forced release at HOLD_MAX splits the packet; the remainder re-arbitrates.
          if (own_valid && tx_ready) begin
            if (release_now) begin
              state    <= S_IDLE;
              grant    <= '0;
              last_win <= owner;
              count    <= 8'd0;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lr35902_dbg_tx_arb.sv
// tb/tb_lr35902_dbg_tx_arb.sv - directed bench for lr35902_dbg_tx_arb (NUM_REQ=4, HOLD_MAX=8)
module tb_lr35902_dbg_tx_arb;

`ifdef DBG_TX_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        tx_valid, tx_ready, busy;
  logic [7:0]  tx_data;

  int vecs = 0;
  int errs = 0;

  logic [8:0] src_mem [4][32];
  int         src_head [4];
  int         src_tail [4];
  logic [3:0] acc;

  logic [7:0] mon_d [256];
  logic [3:0] mon_g [256];
  int         mon_c [256];
  int         mon_n;
  int         cyc;

  logic [7:0] exp_d [64];
  logic [3:0] exp_g [64];
  int         exp_n;

  lr35902_dbg_tx_arb #(.NUM_REQ(4), .HOLD_MAX(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Requester models: pop an accepted byte after the edge, then present the queue heads.
  initial begin
    for (int i = 0; i < 4; i++) begin src_head[i] = 0; end
    req_valid = '0; req_last = '0; req_data = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && src_head[i] != src_tail[i]) src_head[i]++;
        if (src_head[i] != src_tail[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_mem[i][src_head[i] % 32][7:0];
          req_last[i]        = src_mem[i][src_head[i] % 32][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Transfer monitor: signals are stable at the falling edge and transfer on the next rising edge.
  initial begin
    mon_n = 0; cyc = 0; acc = '0;
    forever begin
      @(negedge clk);
      cyc++;
      acc = req_ready & {4{reset_n}};
      if (reset_n && tx_valid && tx_ready && mon_n < 256) begin
        mon_d[mon_n] = tx_data;
        mon_g[mon_n] = grant;
        mon_c[mon_n] = cyc;
        mon_n++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic push(input int i, input logic [7:0] d, input logic l);
    src_mem[i][src_tail[i] % 32] = {l, d};
    src_tail[i]++;
  endtask

  task automatic flush_src();
    for (int i = 0; i < 4; i++) src_tail[i] = src_head[i];
  endtask

  task automatic exp_clr();
    exp_n = 0;
  endtask

  task automatic exp_byte(input int g, input logic [7:0] d);
    exp_d[exp_n] = d;
    exp_g[exp_n] = 4'(1 << g);
    exp_n++;
  endtask

  task automatic exp_tag(input int g);
`ifdef DBG_TX_TAG_EN
    exp_byte(g, 8'hE0 | 8'(g));
`else
    if (g < 0) exp_n = exp_n;
`endif
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    tx_ready = 1'b1;
    flush_src();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_bytes(input int base, input int n);
    for (int c = 0; c < 300 && (mon_n - base) < n; c++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    tx_ready = 1'b1;
    push(0, 8'h99, 1'b1);
    repeat (3) @(negedge clk);
    vecs++; if (grant !== 4'b0000) begin errs++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    flush_src();
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_single();
    int base;
    apply_reset();
    base = mon_n;
    exp_clr(); exp_tag(0);
    exp_byte(0, 8'h11); exp_byte(0, 8'h22); exp_byte(0, 8'h33);
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    for (int c = 0; c < 10 && !req_valid[0]; c++) @(negedge clk);
    vecs++; if (grant !== 4'b0000) begin errs++; $display("FAIL single_pre_grant got=%b exp=0000", grant); end
    @(negedge clk);
    vecs++; if (grant !== 4'b0001) begin errs++; $display("FAIL single_grant_latency got=%b exp=0001", grant); end
    vecs++; if (tx_valid !== 1'b1) begin errs++; $display("FAIL single_first_valid got=%b exp=1", tx_valid); end
    vecs++; if (tx_data !== (TAGN == 1 ? 8'hE0 : 8'h11)) begin errs++; $display("FAIL single_first_data got=%h exp=%h", tx_data, (TAGN == 1 ? 8'hE0 : 8'h11)); end
    wait_bytes(base, exp_n);
    vecs++; if (mon_n - base !== exp_n) begin errs++; $display("FAIL single_count got=%0d exp=%0d", mon_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      vecs++;
      if (mon_d[base+k] !== exp_d[k] || mon_g[base+k] !== exp_g[k]) begin
        errs++; $display("FAIL single_seq[%0d] got=%h/%b exp=%h/%b", k, mon_d[base+k], mon_g[base+k], exp_d[k], exp_g[k]);
      end
    end
    vecs++; if (mon_c[base+TAGN+2] - mon_c[base+TAGN] !== 2) begin errs++; $display("FAIL single_consecutive got=%0d exp=2", mon_c[base+TAGN+2] - mon_c[base+TAGN]); end
    @(negedge clk);
    vecs++; if (grant !== 4'b0000) begin errs++; $display("FAIL single_idle_grant got=%b exp=0000", grant); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int base;
    apply_reset();
    base = mon_n;
    exp_clr();
    for (int r = 0; r < 2; r++) begin
      for (int g = 0; g < 3; g++) begin
        push(g, 8'(8'hA0 + 8'(16*g) + 8'(r)), 1'b1);
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int g = 0; g < 3; g++) begin
        exp_tag(g);
        exp_byte(g, 8'(8'hA0 + 8'(16*g) + 8'(r)));
      end
    end
    wait_bytes(base, exp_n);
    vecs++; if (mon_n - base !== exp_n) begin errs++; $display("FAIL rr_count got=%0d exp=%0d", mon_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      vecs++;
      if (mon_d[base+k] !== exp_d[k] || mon_g[base+k] !== exp_g[k]) begin
        errs++; $display("FAIL rr_seq[%0d] got=%h/%b exp=%h/%b", k, mon_d[base+k], mon_g[base+k], exp_d[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_hold_max();
    int base;
    apply_reset();
    base = mon_n;
    exp_clr();
    for (int b = 1; b <= 10; b++) push(1, 8'(b), (b == 10));
    push(3, 8'h3C, 1'b1);
    exp_tag(1);
    for (int b = 1; b <= 8; b++) exp_byte(1, 8'(b));
    exp_tag(3); exp_byte(3, 8'h3C);
    exp_tag(1); exp_byte(1, 8'h09); exp_byte(1, 8'h0A);
    wait_bytes(base, exp_n);
    vecs++; if (mon_n - base !== exp_n) begin errs++; $display("FAIL hold_count got=%0d exp=%0d", mon_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      vecs++;
      if (mon_d[base+k] !== exp_d[k] || mon_g[base+k] !== exp_g[k]) begin
        errs++; $display("FAIL hold_seq[%0d] got=%h/%b exp=%h/%b", k, mon_d[base+k], mon_g[base+k], exp_d[k], exp_g[k]);
      end
    end
    vecs++; if (mon_c[base+TAGN+8] - mon_c[base+TAGN+7] !== 2) begin errs++; $display("FAIL hold_gap got=%0d exp=2", mon_c[base+TAGN+8] - mon_c[base+TAGN+7]); end
  endtask

  task automatic test_stall();
    int base;
    apply_reset();
    base = mon_n;
    exp_clr(); exp_tag(2);
    for (int b = 1; b <= 4; b++) begin
      push(2, 8'(8'h40 + b), (b == 4));
      exp_byte(2, 8'(8'h40 + b));
    end
    wait_bytes(base, TAGN + 2);
    tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vecs++; if (tx_valid !== 1'b1) begin errs++; $display("FAIL stall_valid[%0d] got=%b exp=1", c, tx_valid); end
      vecs++; if (tx_data !== 8'h43) begin errs++; $display("FAIL stall_data[%0d] got=%h exp=43", c, tx_data); end
      vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL stall_ready[%0d] got=%b exp=0000", c, req_ready); end
      vecs++; if (grant !== 4'b0100) begin errs++; $display("FAIL stall_grant[%0d] got=%b exp=0100", c, grant); end
    end
    @(posedge clk);
    #2 tx_ready = 1'b1;
    wait_bytes(base, exp_n);
    vecs++; if (mon_n - base !== exp_n) begin errs++; $display("FAIL stall_count got=%0d exp=%0d", mon_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      vecs++;
      if (mon_d[base+k] !== exp_d[k] || mon_g[base+k] !== exp_g[k]) begin
        errs++; $display("FAIL stall_seq[%0d] got=%h/%b exp=%h/%b", k, mon_d[base+k], mon_g[base+k], exp_d[k], exp_g[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    base = mon_n;
    for (int b = 1; b <= 4; b++) push(0, 8'(8'h50 + b), (b == 4));
    wait_bytes(base, TAGN + 1);
    reset_n = 1'b0;
    #1;
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL rmid_tx_valid got=%b exp=0", tx_valid); end
    vecs++; if (grant !== 4'b0000) begin errs++; $display("FAIL rmid_grant got=%b exp=0000", grant); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL rmid_req_ready got=%b exp=0000", req_ready); end
    flush_src();
    repeat (2) @(posedge clk);
    #2;
    vecs++; if (mon_n - base !== TAGN + 1) begin errs++; $display("FAIL rmid_emitted got=%0d exp=%0d", mon_n - base, TAGN + 1); end
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    base = mon_n;
    exp_clr();
    push(1, 8'h71, 1'b1);
    push(0, 8'h61, 1'b1);
    exp_tag(0); exp_byte(0, 8'h61);
    exp_tag(1); exp_byte(1, 8'h71);
    wait_bytes(base, exp_n);
    vecs++; if (mon_n - base !== exp_n) begin errs++; $display("FAIL rmid_count got=%0d exp=%0d", mon_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      vecs++;
      if (mon_d[base+k] !== exp_d[k] || mon_g[base+k] !== exp_g[k]) begin
        errs++; $display("FAIL rmid_seq[%0d] got=%h/%b exp=%h/%b", k, mon_d[base+k], mon_g[base+k], exp_d[k], exp_g[k]);
      end
    end
  endtask

`ifdef DBG_TX_TAG_EN
  task automatic test_tag();
    int base;
    apply_reset();
    base = mon_n;
    push(2, 8'hAA, 1'b1);
    wait_bytes(base, 2);
    vecs++; if (mon_n - base !== 2) begin errs++; $display("FAIL tag_count got=%0d exp=2", mon_n - base); end
    vecs++; if (mon_d[base] !== 8'hE2) begin errs++; $display("FAIL tag_byte got=%h exp=e2", mon_d[base]); end
    vecs++; if (mon_d[base+1] !== 8'hAA) begin errs++; $display("FAIL tag_payload got=%h exp=aa", mon_d[base+1]); end
    vecs++; if (mon_g[base] !== 4'b0100) begin errs++; $display("FAIL tag_grant got=%b exp=0100", mon_g[base]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) src_tail[i] = 0;
    reset_n  = 1'b0;
    tx_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_max();
    test_stall();
    test_reset_mid();
`ifdef DBG_TX_TAG_EN
    test_tag();
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
